// File: rtl/csr_trap_sequencer_if.sv
// rtl/csr_trap_sequencer_if.sv - bus bundle between front end, csr_unit and the trap sequencer
// Signals:
//   trap_req/trap_is_irq/trap_cause/trap_pc : trap request and its payload
//   mret_req                                : return-from-trap request
//   pl_*                                    : pipeline CSR access request, pl_gnt = forwarded this cycle
//   csr_*                                   : csr_unit access port (csr_rdata comes back from csr_unit)
//   busy, trap_ack, mret_ack                : sequencer status / acknowledge pulses
//   redirect_valid/redirect_pc              : PC redirect pulse and target
// Modports: slave = the sequencer, master = its surroundings (front end + csr_unit).
interface csr_trap_sequencer_if;
    logic        trap_req;
    logic        trap_is_irq;
    logic [4:0]  trap_cause;
    logic [31:0] trap_pc;
    logic        mret_req;
    logic        pl_req;
    logic        pl_r_en;
    logic        pl_w_en;
    logic [2:0]  pl_op;
    logic [11:0] pl_addr;
    logic [31:0] pl_wdata;
    logic        pl_gnt;
    logic        csr_r_en;
    logic        csr_w_en;
    logic [2:0]  csr_op;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rdata;
    logic        busy;
    logic        trap_ack;
    logic        mret_ack;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    modport slave (
        input  trap_req, trap_is_irq, trap_cause, trap_pc, mret_req,
        input  pl_req, pl_r_en, pl_w_en, pl_op, pl_addr, pl_wdata,
        input  csr_rdata,
        output pl_gnt, csr_r_en, csr_w_en, csr_op, csr_addr, csr_wdata,
        output busy, trap_ack, mret_ack, redirect_valid, redirect_pc
    );

    modport master (
        output trap_req, trap_is_irq, trap_cause, trap_pc, mret_req,
        output pl_req, pl_r_en, pl_w_en, pl_op, pl_addr, pl_wdata,
        output csr_rdata,
        input  pl_gnt, csr_r_en, csr_w_en, csr_op, csr_addr, csr_wdata,
        input  busy, trap_ack, mret_ack, redirect_valid, redirect_pc
    );
endinterface

// File: rtl/csr_trap_sequencer.sv
// rtl/csr_trap_sequencer.sv - sequences trap entry / mret over the single csr_unit port
// Ports:
//   clk : clock, rising edge
//   rst : asynchronous active-low reset
//   bus : csr_trap_sequencer_if.slave (requests, pipeline pass-through, csr_unit port, redirect)
module csr_trap_sequencer #(
    parameter logic [11:0] MSTATUS_ADDR = 12'h300,
    parameter logic [11:0] MTVEC_ADDR   = 12'h305,
    parameter logic [11:0] MEPC_ADDR    = 12'h341,
    parameter logic [11:0] MCAUSE_ADDR  = 12'h342
) (
    input  logic                    clk,
    input  logic                    rst,
    csr_trap_sequencer_if.slave     bus
);

    typedef enum logic [3:0] {
        IDLE,
        T_RD_MS, T_CAP_MS, T_WR_MS, T_WR_MEPC, T_WR_MCAUSE, T_RD_MTV, T_CAP_MTV, T_REDIR,
        R_RD_MS, R_CAP_MS, R_WR_MS, R_RD_MEPC, R_CAP_MEPC, R_REDIR
    } state_e;

    localparam logic [2:0] OP_WRITE = 3'b001;

    state_e      state_q, state_d;
    logic        irq_q, irq_d;
    logic [4:0]  cause_q, cause_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ms_q, ms_d;
    logic [31:0] mtvec_q, mtvec_d;
    logic [31:2] mepc_q, mepc_d;

    logic [31:0] trap_ms, mret_ms, mcause_val, mtvec_base, trap_target;

    // mstatus rewrites: MPIE<=MIE, MIE<=0, MPP<=M on entry; the reverse on mret.
    assign trap_ms    = {ms_q[31:13], 2'b11, ms_q[10:8], ms_q[3], ms_q[6:4], 1'b0, ms_q[2:0]};
    assign mret_ms    = {ms_q[31:13], 2'b00, ms_q[10:8], 1'b1, ms_q[6:4], ms_q[7], ms_q[2:0]};
    assign mcause_val = {irq_q, 26'b0, cause_q};
    assign mtvec_base = {mtvec_q[31:2], 2'b00};
    // Only vectored mode offsets, and only for interrupts; modes 10/11 fall back to direct.
    assign trap_target = (mtvec_q[1:0] == 2'b01 && irq_q)
                       ? mtvec_base + {25'b0, cause_q, 2'b00}
                       : mtvec_base;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            irq_q   <= 1'b0;
            cause_q <= 5'd0;
            pc_q    <= 32'd0;
            ms_q    <= 32'd0;
            mtvec_q <= 32'd0;
            mepc_q  <= 30'd0;
        end else begin
            state_q <= state_d;
            irq_q   <= irq_d;
            cause_q <= cause_d;
            pc_q    <= pc_d;
            ms_q    <= ms_d;
            mtvec_q <= mtvec_d;
            mepc_q  <= mepc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        irq_d   = irq_q;
        cause_d = cause_q;
        pc_d    = pc_q;
        ms_d    = ms_q;
        mtvec_d = mtvec_q;
        mepc_d  = mepc_q;
        case (state_q)
            IDLE: begin
                if (bus.trap_req) begin
                    state_d = T_RD_MS;
                    irq_d   = bus.trap_is_irq;
                    cause_d = bus.trap_cause;
                    pc_d    = bus.trap_pc;
                end else if (bus.mret_req) begin
                    state_d = R_RD_MS;
                end
            end
            T_RD_MS:     state_d = T_CAP_MS;
            T_CAP_MS: begin
                state_d = T_WR_MS;
                ms_d    = bus.csr_rdata;
            end
            T_WR_MS:     state_d = T_WR_MEPC;
            T_WR_MEPC:   state_d = T_WR_MCAUSE;
            T_WR_MCAUSE: state_d = T_RD_MTV;
            T_RD_MTV:    state_d = T_CAP_MTV;
            T_CAP_MTV: begin
                state_d = T_REDIR;
                mtvec_d = bus.csr_rdata;
            end
            T_REDIR:     state_d = IDLE;
            R_RD_MS:     state_d = R_CAP_MS;
            R_CAP_MS: begin
                state_d = R_WR_MS;
                ms_d    = bus.csr_rdata;
            end
            R_WR_MS:     state_d = R_RD_MEPC;
            R_RD_MEPC:   state_d = R_CAP_MEPC;
            R_CAP_MEPC: begin
                state_d = R_REDIR;
                mepc_d  = bus.csr_rdata[31:2];
            end
            R_REDIR:     state_d = IDLE;
            default:     state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.pl_gnt         = 1'b0;
        bus.csr_r_en       = 1'b0;
        bus.csr_w_en       = 1'b0;
        bus.csr_op         = 3'b000;
        bus.csr_addr       = 12'h000;
        bus.csr_wdata      = 32'd0;
        bus.busy           = (state_q != IDLE);
        bus.trap_ack       = 1'b0;
        bus.mret_ack       = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'd0;
        case (state_q)
            IDLE: begin
                bus.pl_gnt = bus.pl_req & ~bus.trap_req & ~bus.mret_req;
                if (bus.pl_gnt) begin
                    bus.csr_r_en  = bus.pl_r_en;
                    bus.csr_w_en  = bus.pl_w_en;
                    bus.csr_op    = bus.pl_op;
                    bus.csr_addr  = bus.pl_addr;
                    bus.csr_wdata = bus.pl_wdata;
                end
            end
            T_RD_MS, T_CAP_MS, R_RD_MS, R_CAP_MS: begin
                bus.csr_r_en = 1'b1;
                bus.csr_addr = MSTATUS_ADDR;
            end
            T_RD_MTV, T_CAP_MTV: begin
                bus.csr_r_en = 1'b1;
                bus.csr_addr = MTVEC_ADDR;
            end
            R_RD_MEPC, R_CAP_MEPC: begin
                bus.csr_r_en = 1'b1;
                bus.csr_addr = MEPC_ADDR;
            end
            T_WR_MS: begin
                bus.csr_w_en  = 1'b1;
                bus.csr_op    = OP_WRITE;
                bus.csr_addr  = MSTATUS_ADDR;
                bus.csr_wdata = trap_ms;
            end
            T_WR_MEPC: begin
                bus.csr_w_en  = 1'b1;
                bus.csr_op    = OP_WRITE;
                bus.csr_addr  = MEPC_ADDR;
                bus.csr_wdata = pc_q;
            end
            T_WR_MCAUSE: begin
                bus.csr_w_en  = 1'b1;
                bus.csr_op    = OP_WRITE;
                bus.csr_addr  = MCAUSE_ADDR;
                bus.csr_wdata = mcause_val;
            end
            R_WR_MS: begin
                bus.csr_w_en  = 1'b1;
                bus.csr_op    = OP_WRITE;
                bus.csr_addr  = MSTATUS_ADDR;
                bus.csr_wdata = mret_ms;
            end
            T_REDIR: begin
                bus.redirect_valid = 1'b1;
                bus.redirect_pc    = trap_target;
                bus.trap_ack       = 1'b1;
            end
            R_REDIR: begin
                bus.redirect_valid = 1'b1;
                bus.redirect_pc    = {mepc_q, 2'b00};
                bus.mret_ack       = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_csr_trap_sequencer.sv
// tb/tb_csr_trap_sequencer.sv - self-checking bench for csr_trap_sequencer
module tb_csr_trap_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    csr_trap_sequencer_if bus ();

    csr_trap_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;
    int ack_cnt = 0;

    logic [31:0] m_ms, m_tv, m_ep, m_mc, m_other;

    typedef struct packed {
        logic [11:0] a;
        logic [31:0] d;
    } wr_t;

    wr_t wlog[$];
    wr_t wexp[$];

    function automatic logic [31:0] rd_model(input logic [11:0] a);
        case (a)
            12'h300: return m_ms;
            12'h305: return m_tv;
            12'h341: return m_ep;
            12'h342: return m_mc;
            default: return m_other;
        endcase
    endfunction

    // csr_unit model: writes land at the rising edge, read data is registered on the falling edge.
    always @(posedge clk) begin
        if (rst && (bus.trap_ack || bus.mret_ack)) ack_cnt++;
        if (rst && bus.csr_w_en) begin
            wlog.push_back({bus.csr_addr, bus.csr_wdata});
            if (bus.csr_op == 3'b001) begin
                case (bus.csr_addr)
                    12'h300: m_ms = bus.csr_wdata;
                    12'h305: m_tv = bus.csr_wdata;
                    12'h341: m_ep = bus.csr_wdata;
                    12'h342: m_mc = bus.csr_wdata;
                    default: m_other = bus.csr_wdata;
                endcase
            end
        end
    end

    always @(negedge clk) begin
        if (bus.csr_r_en) bus.csr_rdata = rd_model(bus.csr_addr);
    end

    // Reference rules, written as field arithmetic on the architectural values.
    function automatic logic [31:0] ms_after_trap(input logic [31:0] ms);
        logic [31:0] mie;
        mie = (ms >> 3) & 32'd1;
        return (ms & ~32'h0000_1888) | (mie << 7) | (32'd3 << 11);
    endfunction

    function automatic logic [31:0] ms_after_mret(input logic [31:0] ms);
        logic [31:0] mpie;
        mpie = (ms >> 7) & 32'd1;
        return (ms & ~32'h0000_1888) | (mpie << 3) | (32'd1 << 7);
    endfunction

    function automatic logic [31:0] trap_dest(input logic [31:0] tv, input logic irq, input int unsigned cause);
        logic [31:0] base;
        base = tv - (tv % 4);
        if ((tv % 4) == 1 && irq) return base + cause * 4;
        return base;
    endfunction

    task automatic clear_inputs();
        bus.trap_req = 0; bus.trap_is_irq = 0; bus.trap_cause = 0; bus.trap_pc = 0;
        bus.mret_req = 0;
        bus.pl_req = 0; bus.pl_r_en = 0; bus.pl_w_en = 0; bus.pl_op = 0;
        bus.pl_addr = 0; bus.pl_wdata = 0;
    endtask

    task automatic check_log(input string name);
        total++;
        if (wlog.size() !== wexp.size()) begin
            bad++;
            $display("FAIL %s write_count got=%0d exp=%0d", name, wlog.size(), wexp.size());
        end else begin
            for (int i = 0; i < wexp.size(); i++) begin
                total++;
                if (wlog[i] !== wexp[i]) begin
                    bad++;
                    $display("FAIL %s write%0d got=%h:%h exp=%h:%h", name, i,
                             wlog[i].a, wlog[i].d, wexp[i].a, wexp[i].d);
                end
            end
        end
    endtask

    task automatic run_trap(input logic [31:0] ms, input logic [31:0] tv, input logic irq,
                            input logic [4:0] cause, input logic [31:0] pc,
                            input bit drop_early, input string name);
        int got;
        logic [31:0] exp_pc;
        m_ms = ms; m_tv = tv;
        wlog.delete(); wexp.delete();
        wexp.push_back({12'h300, ms_after_trap(ms)});
        wexp.push_back({12'h341, pc});
        wexp.push_back({12'h342, (irq ? 32'h8000_0000 : 32'h0) | 32'(cause)});
        exp_pc = trap_dest(tv, irq, cause);
        @(negedge clk);
        bus.trap_req = 1; bus.trap_is_irq = irq; bus.trap_cause = cause; bus.trap_pc = pc;
        got = -1;
        for (int k = 1; k <= 20 && got < 0; k++) begin
            @(negedge clk);
            if (drop_early && k == 2) begin
                bus.trap_req = 0; bus.trap_is_irq = ~irq;
                bus.trap_cause = 5'($urandom); bus.trap_pc = $urandom;
            end
            if (bus.redirect_valid) begin
                got = k;
                total++;
                if (bus.redirect_pc !== exp_pc || bus.trap_ack !== 1'b1 || bus.mret_ack !== 1'b0) begin
                    bad++;
                    $display("FAIL %s redirect pc=%h ack=%b/%b exp pc=%h ack=1/0", name,
                             bus.redirect_pc, bus.trap_ack, bus.mret_ack, exp_pc);
                end
                bus.trap_req = 0;
            end
        end
        total++;
        if (got != 8) begin
            bad++;
            $display("FAIL %s latency got=%0d exp=8", name, got);
        end
        @(negedge clk);
        total++;
        if (bus.redirect_valid !== 1'b0 || bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL %s after_redirect valid=%b busy=%b exp 0/0", name, bus.redirect_valid, bus.busy);
        end
        check_log(name);
    endtask

    task automatic run_mret(input logic [31:0] ms, input logic [31:0] ep, input string name);
        int got;
        logic [31:0] exp_pc;
        m_ms = ms; m_ep = ep;
        wlog.delete(); wexp.delete();
        wexp.push_back({12'h300, ms_after_mret(ms)});
        exp_pc = ep - (ep % 4);
        @(negedge clk);
        bus.mret_req = 1;
        got = -1;
        for (int k = 1; k <= 20 && got < 0; k++) begin
            @(negedge clk);
            if (bus.redirect_valid) begin
                got = k;
                total++;
                if (bus.redirect_pc !== exp_pc || bus.mret_ack !== 1'b1 || bus.trap_ack !== 1'b0) begin
                    bad++;
                    $display("FAIL %s redirect pc=%h ack=%b/%b exp pc=%h ack=0/1", name,
                             bus.redirect_pc, bus.trap_ack, bus.mret_ack, exp_pc);
                end
                bus.mret_req = 0;
            end
        end
        total++;
        if (got != 6) begin
            bad++;
            $display("FAIL %s latency got=%0d exp=6", name, got);
        end
        @(negedge clk);
        check_log(name);
    endtask

    task automatic test_reset();
        clear_inputs();
        repeat (2) @(negedge clk);
        total++;
        if ({bus.busy, bus.pl_gnt, bus.csr_r_en, bus.csr_w_en, bus.trap_ack, bus.mret_ack,
             bus.redirect_valid} !== 7'b0 || bus.redirect_pc !== 32'd0 || bus.csr_wdata !== 32'd0) begin
            bad++;
            $display("FAIL reset_outputs busy=%b gnt=%b r=%b w=%b rv=%b pc=%h exp all 0",
                     bus.busy, bus.pl_gnt, bus.csr_r_en, bus.csr_w_en, bus.redirect_valid, bus.redirect_pc);
        end
        rst = 1;
        m_ms = 32'h8; m_tv = 32'h100;
        @(negedge clk);
        bus.trap_req = 1; bus.trap_cause = 5'd3; bus.trap_pc = 32'h40;
        repeat (3) @(negedge clk);
        total++;
        if (bus.busy !== 1'b1) begin
            bad++;
            $display("FAIL reset_pre_busy got=%b exp=1", bus.busy);
        end
        #2 rst = 0;
        #1;
        total++;
        if ({bus.busy, bus.csr_r_en, bus.csr_w_en, bus.trap_ack, bus.redirect_valid} !== 5'b0) begin
            bad++;
            $display("FAIL reset_async busy=%b r=%b w=%b ack=%b rv=%b exp all 0",
                     bus.busy, bus.csr_r_en, bus.csr_w_en, bus.trap_ack, bus.redirect_valid);
        end
        bus.trap_req = 0;
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        bus.pl_req = 1; bus.pl_r_en = 1; bus.pl_addr = 12'h340;
        #1;
        total++;
        if (bus.busy !== 1'b0 || bus.pl_gnt !== 1'b1) begin
            bad++;
            $display("FAIL reset_release busy=%b gnt=%b exp 0/1", bus.busy, bus.pl_gnt);
        end
        bus.pl_req = 0;
        #1;
        total++;
        if (bus.pl_gnt !== 1'b0 || ack_cnt != 0) begin
            bad++;
            $display("FAIL reset_no_ack gnt=%b acks=%0d exp 0/0", bus.pl_gnt, ack_cnt);
        end
        clear_inputs();
    endtask

    task automatic test_passthrough();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            bus.pl_req = 1; bus.pl_r_en = 1'($urandom); bus.pl_w_en = 1'($urandom);
            bus.pl_op = 3'($urandom); bus.pl_addr = 12'($urandom); bus.pl_wdata = $urandom;
            #1;
            total++;
            if (bus.pl_gnt !== 1'b1 || bus.csr_r_en !== bus.pl_r_en || bus.csr_w_en !== bus.pl_w_en ||
                bus.csr_op !== bus.pl_op || bus.csr_addr !== bus.pl_addr || bus.csr_wdata !== bus.pl_wdata) begin
                bad++;
                $display("FAIL passthru%0d gnt=%b csr=%b%b/%h/%h/%h exp pl=%b%b/%h/%h/%h", i, bus.pl_gnt,
                         bus.csr_r_en, bus.csr_w_en, bus.csr_op, bus.csr_addr, bus.csr_wdata,
                         bus.pl_r_en, bus.pl_w_en, bus.pl_op, bus.pl_addr, bus.pl_wdata);
            end
            bus.pl_req = 0;
            #1;
            total++;
            if (bus.pl_gnt !== 1'b0 || bus.csr_w_en !== 1'b0 || bus.csr_r_en !== 1'b0) begin
                bad++;
                $display("FAIL passthru_idle%0d gnt=%b w=%b r=%b exp 0", i, bus.pl_gnt, bus.csr_w_en, bus.csr_r_en);
            end
        end
        clear_inputs();
    endtask

    task automatic test_arbitration();
        int t_cyc, m_cyc, g_cyc;
        logic [31:0] pc, wd, ms0;
        pc = 32'h0000_1236; wd = $urandom; ms0 = 32'h0000_0008;
        m_ms = ms0; m_tv = 32'h0000_0400; m_other = 32'd0;
        wlog.delete(); wexp.delete();
        wexp.push_back({12'h300, ms_after_trap(ms0)});
        wexp.push_back({12'h341, pc});
        wexp.push_back({12'h342, 32'd2});
        wexp.push_back({12'h300, ms_after_mret(ms_after_trap(ms0))});
        wexp.push_back({12'h340, wd});
        @(negedge clk);
        bus.trap_req = 1; bus.trap_is_irq = 0; bus.trap_cause = 5'd2; bus.trap_pc = pc;
        bus.mret_req = 1;
        bus.pl_req = 1; bus.pl_w_en = 1; bus.pl_op = 3'b001; bus.pl_addr = 12'h340; bus.pl_wdata = wd;
        #1;
        total++;
        if (bus.pl_gnt !== 1'b0) begin
            bad++;
            $display("FAIL arb_gnt0 got=%b exp=0", bus.pl_gnt);
        end
        t_cyc = -1; m_cyc = -1; g_cyc = -1;
        for (int k = 1; k <= 40 && g_cyc < 0; k++) begin
            @(negedge clk);
            if (bus.trap_ack) begin t_cyc = k; bus.trap_req = 0; end
            if (bus.mret_ack) begin
                m_cyc = k; bus.mret_req = 0;
                total++;
                if (bus.redirect_pc !== 32'h0000_1234) begin
                    bad++;
                    $display("FAIL arb_mret_pc got=%h exp=00001234", bus.redirect_pc);
                end
            end
            if (bus.pl_gnt) g_cyc = k;
        end
        @(posedge clk);
        #1 clear_inputs();
        total++;
        if (t_cyc != 8 || m_cyc != 15 || g_cyc != 16) begin
            bad++;
            $display("FAIL arb_order trap=%0d mret=%0d gnt=%0d exp 8/15/16", t_cyc, m_cyc, g_cyc);
        end
        check_log("arb");
        total++;
        if (m_other !== wd) begin
            bad++;
            $display("FAIL arb_pl_write got=%h exp=%h", m_other, wd);
        end
    endtask

    initial begin
        m_ms = 0; m_tv = 0; m_ep = 0; m_mc = 0; m_other = 0;
        bus.csr_rdata = 0;
        test_reset();
        run_trap(32'h0000_0008, 32'h0000_0100, 1'b0, 5'd11, 32'h0000_0080, 1'b0, "direct_trap");
        total++;
        if (m_ms !== 32'h0000_1880 || m_ep !== 32'h80 || m_mc !== 32'h0000_000B) begin
            bad++;
            $display("FAIL direct_trap_csrs ms=%h ep=%h mc=%h exp 00001880/80/0000000b", m_ms, m_ep, m_mc);
        end
        run_trap(32'h0000_0000, 32'h0000_0201, 1'b1, 5'd7, 32'h0000_0300, 1'b0, "vec_irq");
        total++;
        if (m_mc !== 32'h8000_0007) begin
            bad++;
            $display("FAIL vec_irq_mcause got=%h exp=80000007", m_mc);
        end
        run_trap(32'h0000_0000, 32'h0000_0201, 1'b0, 5'd4, 32'h0000_0304, 1'b0, "vec_exc");
        run_mret(32'h0000_1880, 32'h0000_0102, "mret");
        total++;
        if (m_ms !== 32'h0000_0088) begin
            bad++;
            $display("FAIL mret_mstatus got=%h exp=00000088", m_ms);
        end
        for (int i = 0; i < 6; i++)
            run_trap($urandom, $urandom, 1'($urandom), 5'($urandom), $urandom, (i % 2) == 1, "rand_trap");
        for (int i = 0; i < 4; i++)
            run_mret($urandom, $urandom, "rand_mret");
        test_passthrough();
        test_arbitration();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
